fifo_drain_ctrl: RTL and testbench
==================================

Name: fifo_drain_ctrl

Overview:
- Read-side controller sitting directly downstream of the 4-bit-in / 32-bit-out flush-capable FIFO.
- Pops full 32-bit words from the FIFO and delivers them on a valid/ready stream to the consumer.
- Issues the FIFO flush request on an explicit command or when a partial word sits idle for too long.
- Owns the flush handshake so the consumer never has to drive `flush_req` itself.

Parameters:
- DATA_W, 32, FIFO read word width and stream width.
- BUF_DEPTH, 4, output buffer entries; must be ≥ 4 so a full 128-bit flush fits.
- TIMEOUT, 64, idle cycles with partial data before an auto-flush; 0 disables auto-flush.
- TO_W, $clog2(TIMEOUT+1), timeout counter width.

Ports:
- clk  in  1  clock, all flops posedge.
- rst  in  1  asynchronous, active-high reset.
- fifo_vld_rd_data  in  1  FIFO holds at least one complete word.
- fifo_empty  in  1  FIFO holds no data.
- fifo_rd_data  in  DATA_W  FIFO read data; valid the cycle after a pop.
- fifo_flush_done  in  1  FIFO flush complete.
- fifo_rd  out  1  pop one full word.
- fifo_flush_req  out  1  FIFO flush request.
- flush_cmd  in  1  single-cycle flush request from the consumer.
- out_valid  out  1  stream data valid.
- out_data  out  DATA_W  stream data.
- out_ready  in  1  consumer accepts the word.
- flush_busy  out  1  a flush is in progress (any state other than RUN).
- flush_done_o  out  1  one-cycle pulse when all flushed words have been delivered.

Behaviour:
- Reset values: all outputs 0; buffer empty; state RUN; counters 0; pending flag 0.
- Pop rule: `pop = (fifo_rd | fifo_flush_req) & ~fifo_empty`.
  - The word is captured into the buffer on the cycle after the pop.
  - `inflight` is a 1-bit flag set by a pop and cleared on capture.
- Buffer: FIFO of BUF_DEPTH entries. `out_valid = (count != 0)` and `out_data` = head entry. A transfer occurs when `out_valid & out_ready`. Push and pop in the same cycle leave `count` unchanged.
- `fifo_rd` is driven only in RUN, as `fifo_vld_rd_data & (count + inflight + 1 <= BUF_DEPTH)`. Buffer overflow is impossible by construction.
- States:
  - RUN: normal drain. A flush trigger moves to FL_WAIT. Trigger = `flush_cmd`, the pending flag, or the timeout hit.
  - FL_WAIT: `fifo_rd` = 0. Move to FL_REQ when `count == 0 & ~inflight`. If `fifo_empty` at that point, skip directly to FL_DONE (no request is ever issued to an empty FIFO).
  - FL_REQ: `fifo_flush_req` = 1, held continuously until `fifo_flush_done` is sampled high. The FIFO pops one word per cycle (at most 4, the last zero-padded). Each word is captured as above. On `fifo_flush_done`, drop the request and go to FL_DRAIN.
  - FL_DRAIN: wait for `count == 0 & ~inflight`, then go to FL_DONE.
  - FL_DONE: `flush_done_o` = 1 for one cycle, then back to RUN.
- Timeout:
  - The counter increments in RUN while `~fifo_empty & ~fifo_vld_rd_data`.
  - It clears otherwise, and also on entering FL_WAIT.
  - Reaching TIMEOUT is a trigger.
  - With TIMEOUT = 0 the counter is held at 0 and never triggers.
- `flush_cmd` while `flush_busy`: set the pending flag (sticky; multiple commands collapse into one). The flag is consumed on the next RUN cycle.
- `flush_cmd` and a timeout hit in the same cycle produce a single flush.
- The FIFO may accept new writes during a flush. The controller delivers them only after returning to RUN.
- Reset asserted mid-flush: immediate return to reset values; `fifo_flush_req` drops asynchronously.
- Back-pressure (`out_ready` = 0) never drops or reorders data.

Optional Feature:
- Macro: FIFO_DRAIN_STATS_EN.
- Defined: adds outputs `stat_words [15:0]` and `stat_flushes [7:0]`.
  - Both are saturating counters, reset to 0.
  - `stat_words` increments on each stream transfer.
  - `stat_flushes` increments on each `flush_done_o` pulse.
- Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Normal drain: FIFO presents words 0x11111111, 0x22222222, 0x33333333 with `out_ready` = 1 → `fifo_rd` issued for each, the same three words appear in order on `out_data`, and `fifo_flush_req` is never asserted.
- Back-pressure: 4 words available, `out_ready` = 0 for 10 cycles → exactly 4 pops, `fifo_rd` held low afterwards, `out_data` stable at the first word; `out_ready` = 1 → all 4 words delivered in 4 consecutive cycles.
- Explicit flush with partial data: FIFO holds 12 bits (0x00000ABC after padding), `flush_cmd` pulse → FL_WAIT → `fifo_flush_req` held until `fifo_flush_done`, 0x00000ABC delivered, `flush_done_o` pulses once, state returns to RUN.
- Auto-flush: TIMEOUT = 8, FIFO non-empty with `fifo_vld_rd_data` = 0 for 8 cycles → flush begins on cycle 8; the counter clears whenever `fifo_vld_rd_data` rises earlier.
- Command during flush: a second `flush_cmd` while `flush_busy` = 1 → exactly one extra flush after the first `flush_done_o`; two commands in that window still produce exactly one.
- Reset mid-FL_REQ: assert `rst` → `fifo_flush_req`, `out_valid`, `flush_busy` all 0 immediately; after release, normal drain resumes (with FIFO_DRAIN_STATS_EN, both stat counters read 0).

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the 4b-in/32b-out flush FIFO: pops words into a small
// output buffer, streams them out, and runs the flush handshake. FIFO_DRAIN_STATS_EN adds stat counters.
module fifo_drain_ctrl #(
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 4,
   parameter int TIMEOUT   = 64,
   parameter int TO_W      = $clog2(TIMEOUT+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_vld_rd_data,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rd_data,
   input  logic              fifo_flush_done,
   output logic              fifo_rd,
   output logic              fifo_flush_req,
   input  logic              flush_cmd,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              flush_busy,
   output logic              flush_done_o
`ifdef FIFO_DRAIN_STATS_EN
   ,
   output logic [15:0]       stat_words,
   output logic [7:0]        stat_flushes
`endif
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH+1);
   localparam int TC_W  = (TO_W < 1) ? 1 : TO_W;

   typedef enum logic [2:0] {RUN, FL_WAIT, FL_REQ, FL_DRAIN, FL_DONE} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] buf_q [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              inflight_q;
   logic              pend_q;
   logic [TC_W-1:0]   to_q;

   logic              pop, push, xfer, room, drained, to_inc, to_hit, trig;
   logic [CNT_W:0]    occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A word in flight already owns a buffer slot, so it counts toward occupancy.
   assign occ       = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);
   assign room      = occ < (CNT_W+1)'(BUF_DEPTH);
   assign fifo_rd   = (state_q == RUN) & fifo_vld_rd_data & room;
   assign pop       = (fifo_rd | fifo_flush_req) & ~fifo_empty;
   assign push      = inflight_q;
   assign out_valid = (count_q != '0);
   assign out_data  = buf_q[rd_ptr_q];
   assign xfer      = out_valid & out_ready;
   assign drained   = (count_q == '0) & ~inflight_q;

   assign to_inc = (state_q == RUN) & ~fifo_empty & ~fifo_vld_rd_data;
   assign to_hit = (TIMEOUT != 0) && (to_q == TC_W'(TIMEOUT));
   assign trig   = flush_cmd | pend_q | to_hit;

   always_ff @(posedge clk)
      if (push) buf_q[wr_ptr_q] <= fifo_rd_data;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= pop;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (xfer) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !xfer)      count_q <= count_q + CNT_W'(1);
         else if (xfer && !push) count_q <= count_q - CNT_W'(1);
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q        <= RUN;
         fifo_flush_req <= 1'b0;
         flush_busy     <= 1'b0;
         flush_done_o   <= 1'b0;
         pend_q         <= 1'b0;
         to_q           <= '0;
      end else begin
         flush_done_o <= 1'b0;
         to_q         <= '0;
         if (flush_busy && flush_cmd) pend_q <= 1'b1;
         case (state_q)
            RUN: begin
               if (TIMEOUT != 0 && to_inc && !to_hit) to_q <= to_q + TC_W'(1);
               if (trig) begin
                  state_q    <= FL_WAIT;
                  flush_busy <= 1'b1;
                  pend_q     <= 1'b0;
                  to_q       <= '0;
               end
            end
            FL_WAIT:
               if (drained) begin
                  if (fifo_empty) begin
                     state_q      <= FL_DONE;
                     flush_done_o <= 1'b1;
                  end else begin
                     state_q        <= FL_REQ;
                     fifo_flush_req <= 1'b1;
                  end
               end
            FL_REQ:
               if (fifo_flush_done) begin
                  fifo_flush_req <= 1'b0;
                  state_q        <= FL_DRAIN;
               end
            FL_DRAIN:
               if (drained) begin
                  state_q      <= FL_DONE;
                  flush_done_o <= 1'b1;
               end
            FL_DONE: begin
               state_q    <= RUN;
               flush_busy <= 1'b0;
            end
            default: begin
               state_q        <= RUN;
               flush_busy     <= 1'b0;
               fifo_flush_req <= 1'b0;
            end
         endcase
      end

`ifdef FIFO_DRAIN_STATS_EN
   logic [15:0] words_q;
   logic [7:0]  flushes_q;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         words_q   <= '0;
         flushes_q <= '0;
      end else begin
         if (xfer && words_q != '1)           words_q   <= words_q + 16'd1;
         if (flush_done_o && flushes_q != '1) flushes_q <= flushes_q + 8'd1;
      end

   assign stat_words   = words_q;
   assign stat_flushes = flushes_q;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: nibble-level model of the upstream flush FIFO plus a word
// scoreboard of what the output buffer must hold; directed steps followed by a random phase.
module tb_fifo_drain_ctrl;
   localparam int DW = 32;
   localparam int BD = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_vld_rd_data = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_flush_done = 1'b0;
   logic          fifo_rd, fifo_flush_req;
   logic          flush_cmd = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b1;
   logic          flush_busy, flush_done_o;
`ifdef FIFO_DRAIN_STATS_EN
   logic [15:0]   stat_words;
   logic [7:0]    stat_flushes;
`endif

   fifo_drain_ctrl #(.DATA_W(DW), .BUF_DEPTH(BD), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .fifo_vld_rd_data(fifo_vld_rd_data), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_flush_done(fifo_flush_done),
      .fifo_rd(fifo_rd), .fifo_flush_req(fifo_flush_req),
      .flush_cmd(flush_cmd), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .flush_busy(flush_busy), .flush_done_o(flush_done_o)
`ifdef FIFO_DRAIN_STATS_EN
      , .stat_words(stat_words), .stat_flushes(stat_flushes)
`endif
   );

   always #5 clk = ~clk;

   logic [3:0]  nq[$];
   logic [31:0] sb[$];
   logic [31:0] delivered[$];
   bit          inflt, req_prev, hold_done;
   int          tests, fails, n_rd, n_done, n_req;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check1(input string tag, input logic got, input logic exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic drive_fifo();
      fifo_vld_rd_data = (nq.size() >= 8);
      fifo_empty       = (nq.size() == 0);
   endtask

   task automatic wr(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) nq.push_back(w[4*i +: 4]);
      drive_fifo();
   endtask

   function automatic logic [31:0] take_word();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 8; i++)
         if (nq.size() != 0) w[4*i +: 4] = nq.pop_front();
      return w;
   endfunction

   // One clock: check at the falling edge, then advance the models just after the rising edge.
   task automatic tick(input bit cmd);
      bit pop, xfer, req_s;
      logic [31:0] w;
      flush_cmd = cmd;
      @(negedge clk);
      check1("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) check("out_data", out_data, sb[0]);
      if (flush_busy) check1("rd_in_flush", fifo_rd, 1'b0);
      else check1("rd_rule", fifo_rd, fifo_vld_rd_data && (sb.size() + int'(inflt) < BD));
      if (flush_done_o) check("done_buf_empty", 32'(sb.size()), 32'd0);
      if (fifo_flush_req && !req_prev) check1("req_nonempty", fifo_empty, 1'b0);
      pop   = (fifo_rd | fifo_flush_req) & ~fifo_empty;
      xfer  = out_valid & out_ready;
      req_s = fifo_flush_req;
      req_prev = req_s;
      if (fifo_rd) n_rd++;
      if (flush_done_o) n_done++;
      if (fifo_flush_req) n_req++;
      @(posedge clk);
      #1;
      flush_cmd = 1'b0;
      if (xfer) delivered.push_back(sb.pop_front());
      if (inflt) sb.push_back(fifo_rd_data);
      inflt = pop;
      if (pop) begin
         w = take_word();
         fifo_rd_data = w;
      end
      fifo_flush_done = req_s && (nq.size() == 0) && !fifo_flush_done && !hold_done;
      drive_fifo();
   endtask

   task automatic run_idle();
      int k;
      k = 0;
      while ((flush_busy || sb.size() != 0 || inflt) && k < 300) begin
         tick(1'b0);
         k++;
      end
      check1("settle_in_budget", k < 300, 1'b1);
   endtask

   task automatic model_clear();
      nq.delete();
      sb.delete();
      inflt = 0;
      req_prev = 0;
      hold_done = 0;
      fifo_flush_done = 1'b0;
      drive_fifo();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0, q0;
      logic [31:0] w4[4];
      bit seen;

      // Reset state
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check1("rst_fifo_rd", fifo_rd, 1'b0);
      check1("rst_flush_req", fifo_flush_req, 1'b0);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_busy", flush_busy, 1'b0);
      check1("rst_done", flush_done_o, 1'b0);
`ifdef FIFO_DRAIN_STATS_EN
      check("rst_stat_words", 32'(stat_words), 32'd0);
      check("rst_stat_flushes", 32'(stat_flushes), 32'd0);
`endif
      rst = 1'b0;

      // Normal drain of three full words
      out_ready = 1'b1;
      r0 = n_rd; q0 = n_req;
      wr(32'h11111111, 8); wr(32'h22222222, 8); wr(32'h33333333, 8);
      repeat (12) tick(1'b0);
      check("drain_cnt", 32'(delivered.size()), 32'd3);
      check("drain_w0", delivered[0], 32'h11111111);
      check("drain_w1", delivered[1], 32'h22222222);
      check("drain_w2", delivered[2], 32'h33333333);
      check("drain_pops", 32'(n_rd - r0), 32'd3);
      check("drain_no_req", 32'(n_req - q0), 32'd0);

      // Back-pressure: four pops fill the buffer, further words wait in the FIFO
      delivered.delete();
      out_ready = 1'b0;
      r0 = n_rd;
      for (int i = 0; i < 4; i++) begin
         w4[i] = $urandom;
         wr(w4[i], 8);
      end
      repeat (5) tick(1'b0);
      wr(32'hCAFEF00D, 8);
      repeat (5) tick(1'b0);
      check("bp_pops", 32'(n_rd - r0), 32'd4);
      check1("bp_rd_low", fifo_rd, 1'b0);
      check1("bp_vld_waiting", fifo_vld_rd_data, 1'b1);
      check("bp_head", out_data, w4[0]);
      out_ready = 1'b1;
      repeat (4) tick(1'b0);
      check("bp_burst_cnt", 32'(delivered.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("bp_order", delivered[i], w4[i]);
      run_idle();
      check("bp_fifth", delivered[delivered.size()-1], 32'hCAFEF00D);

      // Explicit flush of a 12-bit partial word
      delivered.delete();
      d0 = n_done; q0 = n_req;
      wr(32'h00000ABC, 3);
      tick(1'b1);
      check1("fl_busy", flush_busy, 1'b1);
      run_idle();
      check("fl_word", delivered[delivered.size()-1], 32'h00000ABC);
      check("fl_done_pulses", 32'(n_done - d0), 32'd1);
      check1("fl_req_seen", (n_req - q0) > 0, 1'b1);
      check1("fl_back_run", flush_busy, 1'b0);

      // Auto-flush after TO idle cycles with partial data
      delivered.delete();
      d0 = n_done;
      wr(32'h5, 3);
      repeat (8) tick(1'b0);
      check1("to_not_yet", flush_busy, 1'b0);
      tick(1'b0);
      check1("to_fired", flush_busy, 1'b1);
      run_idle();
      check("to_word", delivered[0], 32'h5);
      check("to_done", 32'(n_done - d0), 32'd1);

      // Timeout counter restarts when a full word becomes available
      delivered.delete();
      wr(32'h7, 3);
      repeat (5) tick(1'b0);
      wr(32'h87654321, 8);
      repeat (9) tick(1'b0);
      check1("to_restart_quiet", flush_busy, 1'b0);
      tick(1'b0);
      check1("to_restart_fire", flush_busy, 1'b1);
      run_idle();
      check("to_rs_w0", delivered[0], 32'h54321007);
      check("to_rs_w1", delivered[1], 32'h00000876);

      // Commands during a flush collapse into one extra flush
      delivered.delete();
      d0 = n_done;
      wr(32'h9, 2);
      tick(1'b1);
      check1("cmd_busy_a", flush_busy, 1'b1);
      tick(1'b1);
      check1("cmd_busy_b", flush_busy, 1'b1);
      tick(1'b0);
      tick(1'b1);
      run_idle();
      repeat (3) tick(1'b0);
      run_idle();
      repeat (3) tick(1'b0);
      check("cmd_two_flushes", 32'(n_done - d0), 32'd2);
      check("cmd_word", delivered[0], 32'h9);

      // Reset asserted while the flush request is held
      hold_done = 1;
      wr(32'hDEF, 3);
      tick(1'b1);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick(1'b0);
         seen = fifo_flush_req;
      end
      check1("mid_req_reached", seen, 1'b1);
      #1 rst = 1'b1;
      #1;
      check1("arst_req", fifo_flush_req, 1'b0);
      check1("arst_valid", out_valid, 1'b0);
      check1("arst_busy", flush_busy, 1'b0);
      model_clear();
      delivered.delete();
      @(posedge clk);
      #1;
`ifdef FIFO_DRAIN_STATS_EN
      check("arst_stat_words", 32'(stat_words), 32'd0);
      check("arst_stat_flushes", 32'(stat_flushes), 32'd0);
`endif
      rst = 1'b0;
      wr(32'h0BADBEEF, 8); wr(32'h12345678, 8);
      repeat (8) tick(1'b0);
      check("post_rst_cnt", 32'(delivered.size()), 32'd2);
      check("post_rst_w0", delivered[0], 32'h0BADBEEF);
      check("post_rst_w1", delivered[1], 32'h12345678);

      // Random traffic, back-pressure and commands
      for (int i = 0; i < 500; i++) begin
         int n;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!fifo_flush_req && $urandom_range(0, 2) == 0 && nq.size() < 32) begin
            n = $urandom_range(1, 8);
            if (n > 32 - nq.size()) n = 32 - nq.size();
            wr($urandom, n);
         end
         tick($urandom_range(0, 39) == 0);
      end
      out_ready = 1'b1;
      repeat (3) tick(1'b0);
      run_idle();
      tick(1'b1);
      run_idle();
      repeat (3) tick(1'b0);
      run_idle();
      check("rand_fifo_drained", 32'(nq.size()), 32'd0);
      check("rand_buf_empty", 32'(sb.size()), 32'd0);
      check1("rand_idle", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
